// File: rtl/hpi_pkg.sv
// hpi_pkg: shared op/state types and HPI register map for the HPI command sequencer.
package hpi_pkg;

  typedef enum logic [1:0] {
    REG_RD = 2'd0,
    REG_WR = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } hpi_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } hpi_state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  function automatic logic op_is_mem(input hpi_op_t op);
    return (op == MEM_RD) || (op == MEM_WR);
  endfunction

  function automatic logic op_is_read(input hpi_op_t op);
    return (op == REG_RD) || (op == MEM_RD);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpi_master.sv
// hpi_master: turns single-cycle host commands into timed HPI bus cycles for hpi_io_intf.
// MEM ops run two HPI cycles back to back: address-register write, then data access.
//
// state   | meaning
// IDLE    | cs high, ready for a command
// SETUP   | cs low, address/data stable, strobes high
// STROBE  | read or write strobe low
// HOLD    | strobes high, cs low; read data captured on first cycle
// RECOVER | cs high; next phase or response on last cycle
module hpi_master
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  hpi_op_t     cmd_op,
  input  logic [1:0]  cmd_reg,
  input  logic [15:0] cmd_maddr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_cs_n
);

  localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYC, STROBE_CYC),
                                          max_u(HOLD_CYC, RECOVER_CYC));
  localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);
  localparam logic             REC_ONE    = (RECOVER_CYC == 1);

  hpi_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  hpi_op_t          r_op;
  logic [15:0]      r_wdata;

  logic w_cnt_done;
  logic w_rd_cycle;

  assign w_cnt_done = (r_cnt == '0);
  // The address phase is always a write; only the data phase follows the op direction.
  assign w_rd_cycle = r_phase && op_is_read(r_op);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_op         <= REG_RD;
      r_wdata      <= '0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      busy         <= 1'b0;
      hpi_addr     <= '0;
      hpi_data_out <= '0;
      hpi_r_n      <= 1'b1;
      hpi_w_n      <= 1'b1;
      hpi_cs_n     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_op    <= cmd_op;
            r_wdata <= cmd_wdata;
            if (op_is_mem(cmd_op)) begin
              r_phase      <= 1'b0;
              hpi_addr     <= HPI_ADDR;
              hpi_data_out <= cmd_maddr;
            end else begin
              r_phase      <= 1'b1;
              hpi_addr     <= cmd_reg;
              hpi_data_out <= cmd_wdata;
            end
            r_state   <= SETUP;
            r_cnt     <= SETUP_LD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            hpi_cs_n  <= 1'b0;
          end
        end

        SETUP: begin
          if (w_cnt_done) begin
            r_state <= STROBE;
            r_cnt   <= STROBE_LD;
            hpi_r_n <= !w_rd_cycle;
            hpi_w_n <= w_rd_cycle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        STROBE: begin
          if (w_cnt_done) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_LD;
            hpi_r_n <= 1'b1;
            hpi_w_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        HOLD: begin
          // hpi_io_intf registers the bus, so read data lands here rather than in STROBE.
          if (w_rd_cycle && (r_cnt == HOLD_LD)) begin
            rsp_rdata <= hpi_data_in;
          end
          if (w_cnt_done) begin
            r_state   <= RECOVER;
            r_cnt     <= RECOVER_LD;
            hpi_cs_n  <= 1'b1;
            rsp_valid <= r_phase && REC_ONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        RECOVER: begin
          if (w_cnt_done) begin
            if (!r_phase) begin
              r_phase      <= 1'b1;
              hpi_addr     <= HPI_DATA;
              hpi_data_out <= r_wdata;
              r_state      <= SETUP;
              r_cnt        <= SETUP_LD;
              hpi_cs_n     <= 1'b0;
            end else begin
              r_state   <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            r_cnt     <= r_cnt - 1'b1;
            rsp_valid <= r_phase && (r_cnt == CNT_W'(1));
          end
        end

        default: begin
          r_state   <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          hpi_cs_n  <= 1'b1;
          hpi_r_n   <= 1'b1;
          hpi_w_n   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpi_master.sv
// tb_hpi_master: directed checks of hpi_master timing with a small hpi_io_intf/device model.
`timescale 1ns/1ps
module tb_hpi_master;
  import hpi_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  hpi_op_t     cmd_op = REG_RD;
  logic [1:0]  cmd_reg = 2'd0;
  logic [15:0] cmd_maddr = 16'h0;
  logic [15:0] cmd_wdata = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_out;
  logic [15:0] hpi_data_in = 16'h0;
  logic        hpi_r_n, hpi_w_n, hpi_cs_n;

  hpi_master dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .cmd_maddr(cmd_maddr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
    .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_cs_n(hpi_cs_n)
  );

  always #5 Clk = ~Clk;

  // hpi_io_intf registers the read strobe to the pin and the pin data back in;
  // the device drives dev_word only while its read pin is low.
  logic        pin_r_n = 1'b1;
  logic [15:0] dev_word = 16'h0;
  always @(posedge Clk) begin
    pin_r_n     <= hpi_r_n;
    hpi_data_in <= pin_r_n ? 16'hDEAD : dev_word;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Per-cycle traces; bit k / entry k = cycle k, cycle 0 being the accept cycle.
  logic [31:0] t_cs, t_rn, t_wn, t_rv, t_rdy, t_busy;
  logic [1:0]  a_at [32];
  logic [15:0] d_at [32];
  logic [15:0] q_at [32];

  task automatic sample(input int k);
    t_cs[k]   = ~hpi_cs_n;
    t_rn[k]   = ~hpi_r_n;
    t_wn[k]   = ~hpi_w_n;
    t_rv[k]   = rsp_valid;
    t_rdy[k]  = cmd_ready;
    t_busy[k] = busy;
    a_at[k]   = hpi_addr;
    d_at[k]   = hpi_data_out;
    q_at[k]   = rsp_rdata;
  endtask

  // Caller presents the command in cycle 0; two_cmd keeps cmd_valid high for a second REG_RD.
  task automatic run(input int ncyc, input bit two_cmd);
    t_cs = '0; t_rn = '0; t_wn = '0; t_rv = '0; t_rdy = '0; t_busy = '0;
    sample(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge Clk); #1;
      if (two_cmd) begin
        if (k == 1) cmd_reg = 2'd1;
        if (k == 9) dev_word = 16'h5678;
        if (k == 10) cmd_valid = 1'b0;
      end else if (k == 1) begin
        cmd_valid = 1'b0;
      end
      sample(k);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge Clk); #1; end
  endtask

  initial begin
    int rv_seen;

    // 1: reset
    idle(3);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_val("rst_strobes", {29'd0, hpi_cs_n, hpi_r_n, hpi_w_n}, 32'h7);
    check_val("rst_addr", 32'(hpi_addr), 32'h0);
    check_val("rst_dout", 32'(hpi_data_out), 32'h0);
    check_val("rst_ready_rv_busy", {29'd0, cmd_ready, rsp_valid, busy}, 32'h4);
    check_val("rst_rdata", 32'(rsp_rdata), 32'h0);

    // 2: REG_WR reg 1, A5A5
    cmd_op = REG_WR; cmd_reg = 2'd1; cmd_wdata = 16'hA5A5; cmd_maddr = 16'h7777;
    cmd_valid = 1'b1;
    run(10, 1'b0);
    check_val("regwr_cs", t_cs, mask(1, 6));
    check_val("regwr_wn", t_wn, mask(2, 5));
    check_val("regwr_rn", t_rn, 32'h0);
    check_val("regwr_rv", t_rv, mask(8, 8));
    check_val("regwr_ready", t_rdy, mask(0, 0) | mask(9, 10));
    check_val("regwr_busy", t_busy, mask(1, 8));
    check_val("regwr_addr_c1", 32'(a_at[1]), 32'h1);
    check_val("regwr_addr_c10", 32'(a_at[10]), 32'h1);
    check_val("regwr_dout_c1", 32'(d_at[1]), 32'hA5A5);
    check_val("regwr_dout_c8", 32'(d_at[8]), 32'hA5A5);

    // 3: REG_RD reg 3, device returns 1234
    idle(2);
    cmd_op = REG_RD; cmd_reg = 2'd3; dev_word = 16'h1234;
    cmd_valid = 1'b1;
    run(10, 1'b0);
    check_val("regrd_rn", t_rn, mask(2, 5));
    check_val("regrd_wn", t_wn, 32'h0);
    check_val("regrd_rv", t_rv, mask(8, 8));
    check_val("regrd_addr", 32'(a_at[3]), 32'h3);
    check_val("regrd_rdata_c8", 32'(q_at[8]), 32'h1234);
    check_val("regrd_rdata_held", 32'(q_at[10]), 32'h1234);

    // 4: MEM_WR 0500 <- BEEF
    idle(2);
    cmd_op = MEM_WR; cmd_maddr = 16'h0500; cmd_wdata = 16'hBEEF; cmd_reg = 2'd3;
    cmd_valid = 1'b1;
    run(18, 1'b0);
    check_val("memwr_cs", t_cs, mask(1, 6) | mask(9, 14));
    check_val("memwr_wn", t_wn, mask(2, 5) | mask(10, 13));
    check_val("memwr_rn", t_rn, 32'h0);
    check_val("memwr_rv", t_rv, mask(16, 16));
    check_val("memwr_ready", t_rdy, mask(0, 0) | mask(17, 18));
    check_val("memwr_ph0", {a_at[1], d_at[1]}, {14'd0, 2'd2, 16'h0500});
    check_val("memwr_ph0_held", {a_at[8], d_at[8]}, {14'd0, 2'd2, 16'h0500});
    check_val("memwr_ph1", {a_at[9], d_at[9]}, {14'd0, 2'd0, 16'hBEEF});
    check_val("memwr_rdata_kept", 32'(q_at[16]), 32'h1234);

    // 6: two REG_RD with cmd_valid held high
    idle(2);
    cmd_op = REG_RD; cmd_reg = 2'd3; dev_word = 16'h1234;
    cmd_valid = 1'b1;
    run(20, 1'b1);
    check_val("b2b_ready", t_rdy, mask(0, 0) | mask(9, 9) | mask(18, 20));
    check_val("b2b_rv", t_rv, mask(8, 8) | mask(17, 17));
    check_val("b2b_rn", t_rn, mask(2, 5) | mask(11, 14));
    check_val("b2b_addr1", 32'(a_at[2]), 32'h3);
    check_val("b2b_addr2", 32'(a_at[11]), 32'h1);
    check_val("b2b_rdata1", 32'(q_at[8]), 32'h1234);
    check_val("b2b_rdata2", 32'(q_at[17]), 32'h5678);

    // 5: MEM_RD aborted by reset in phase-1 STROBE (cycle 10)
    idle(2);
    cmd_op = MEM_RD; cmd_maddr = 16'h0ABC; cmd_wdata = 16'h0000; dev_word = 16'h9999;
    cmd_valid = 1'b1;
    run(10, 1'b0);
    check_val("memrd_ph0_wn", t_wn, mask(2, 5));
    check_val("memrd_ph0", {a_at[1], d_at[1]}, {14'd0, 2'd2, 16'h0ABC});
    check_val("memrd_ph1_addr", 32'(a_at[9]), 32'h0);
    check_val("memrd_rn_c10", 32'(t_rn[10]), 32'h1);
    Reset = 1'b1;
    #1;
    check_val("abort_strobes", {29'd0, hpi_cs_n, hpi_r_n, hpi_w_n}, 32'h7);
    check_val("abort_busy_rv", {30'd0, busy, rsp_valid}, 32'h0);
    check_val("abort_addr_dout", {hpi_addr, hpi_data_out}, 32'h0);
    check_val("abort_rdata", 32'(rsp_rdata), 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_val("abort_ready", {30'd0, cmd_ready, busy}, 32'h2);
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) rv_seen++;
      @(posedge Clk); #1;
    end
    check_val("abort_no_rsp", 32'(rv_seen), 32'h0);
    check_val("abort_idle_cs", 32'(hpi_cs_n), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
